// File: rtl/srlatch_handshake_arbiter.sv
// Round-robin arbiter that shares one asynchronous SR latch among NREQ
// synchronous requesters. It runs a four-phase handshake on s/r/ack and
// returns the settled latch value with a one-cycle done pulse to the winner.
// A sticky err is raised if ack stalls in either phase.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   req    - per-requester request level
//   op     - per-requester operation (1 = set, 0 = reset), sampled at grant
//   grant  - one-hot, high for the whole transaction of the winner
//   done   - one-hot, one-cycle pulse at transaction completion
//   q_out  - synchronized latch value captured at completion
//   err    - sticky handshake-timeout flag
//   s, r   - latch set / reset requests
//   ack, q - asynchronous latch acknowledge / state
module srlatch_handshake_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            q_out,
  output logic            err,
  output logic            s,
  output logic            r,
  input  logic            ack,
  input  logic            q
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GRANT = 3'd1;
  localparam logic [2:0] RAISE = 3'd2;
  localparam logic [2:0] LOWER = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [PW-1:0]          win_q, win_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic                   op_q, op_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic [NREQ-1:0]        done_q, done_d;
  logic                   q_out_q, q_out_d;
  logic                   err_q, err_d;
  logic                   s_q, s_d;
  logic                   r_q, r_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [SYNC_STAGES-1:0] q_sync_q;

  logic                   ack_s;
  logic                   q_s;
  logic                   pick_found;
  logic [PW-1:0]          pick_idx;
  logic [NREQ-1:0]        win_oh;
  logic [PW-1:0]          ptr_next;
  logic                   cnt_expired;

  assign ack_s       = ack_sync_q[SYNC_STAGES-1];
  assign q_s         = q_sync_q[SYNC_STAGES-1];
  assign win_oh      = NREQ'(1) << win_q;
  assign ptr_next    = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
  assign cnt_expired = (cnt_q == CW'(TIMEOUT - 1));

  // Round-robin pick: first pending request at or above ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      logic [PW-1:0] idx;
      idx = PW'((32'(ptr_q) + i) % NREQ);
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = '0;
    q_out_d = q_out_q;
    err_d   = err_q;
    s_d     = s_q;
    r_d     = r_q;

    case (state_q)
      IDLE: begin
        // Hold off while the latch is still acknowledging an earlier cycle.
        if (pick_found && !ack_s) begin
          win_d   = pick_idx;
          op_d    = op[pick_idx];
          state_d = GRANT;
        end
      end
      GRANT: begin
        grant_d = win_oh;
        cnt_d   = '0;
        state_d = RAISE;
      end
      RAISE: begin
        if (ack_s) begin
          s_d     = 1'b0;
          r_d     = 1'b0;
          cnt_d   = '0;
          state_d = LOWER;
        end else if (cnt_expired) begin
          s_d     = 1'b0;
          r_d     = 1'b0;
          grant_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ERR;
        end else begin
          s_d   = op_q;
          r_d   = ~op_q;
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOWER: begin
        s_d = 1'b0;
        r_d = 1'b0;
        if (!ack_s) begin
          done_d  = win_oh;
          q_out_d = q_s;
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_expired) begin
          grant_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        grant_d = '0;
        ptr_d   = ptr_next;
        state_d = IDLE;
      end
      ERR: begin
        s_d     = 1'b0;
        r_d     = 1'b0;
        grant_d = '0;
        err_d   = 1'b1;
      end
      default: begin
        s_d     = 1'b0;
        r_d     = 1'b0;
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, output and synchronizer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      ptr_q      <= '0;
      op_q       <= 1'b0;
      cnt_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      q_out_q    <= 1'b0;
      err_q      <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      ack_sync_q <= '0;
      q_sync_q   <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      ptr_q      <= ptr_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      q_out_q    <= q_out_d;
      err_q      <= err_d;
      s_q        <= s_d;
      r_q        <= r_d;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack};
      q_sync_q   <= {q_sync_q[SYNC_STAGES-2:0], q};
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign q_out = q_out_q;
  assign err   = err_q;
  assign s     = s_q;
  assign r     = r_q;

endmodule

// File: tb/tb_srlatch_handshake_arbiter.sv
// Self-checking bench for srlatch_handshake_arbiter: behavioural SR latch,
// table of single transactions, randomized round-robin traffic against a
// transaction-level model, and hand sequences for latency, dropped request,
// reset mid-handshake and timeout.
module tb_srlatch_handshake_arbiter;

  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req, op, grant, done;
  logic            q_out, err, s, r, ack, q;

  always #5 clk = ~clk;

  srlatch_handshake_arbiter #(
    .NREQ(NREQ), .TIMEOUT(255), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .grant(grant), .done(done),
    .q_out(q_out), .err(err), .s(s), .r(r), .ack(ack), .q(q)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural SR latch: acks ack_dly cycles after s/r rises, releases
  // ack rel_dly cycles after both drop; ack_never models a dead latch.
  int ack_dly   = 3;
  int rel_dly   = 2;
  bit ack_never = 1'b0;
  int lat_cnt   = 0;

  always @(negedge clk) begin
    if ((s || r) && !ack) begin
      if (ack_never) lat_cnt = 0;
      else if (lat_cnt >= ack_dly - 1) begin
        q = s; ack = 1'b1; lat_cnt = 0;
      end else lat_cnt++;
    end else if (!(s || r) && ack) begin
      if (lat_cnt >= rel_dly - 1) begin
        ack = 1'b0; lat_cnt = 0;
      end else lat_cnt++;
    end else lat_cnt = 0;
  end

  // Protocol monitor: s/r exclusive, grant and done at most one-hot.
  bit saw_s, saw_r;
  always @(negedge clk) begin
    if (s) saw_s = 1'b1;
    if (r) saw_r = 1'b1;
    if (!rst) begin
      tests++;
      if ((s && r) || !$onehot0(grant) || !$onehot0(done)) begin
        fails++;
        $display("FAIL monitor: s=%b r=%b grant=%b done=%b", s, r, grant, done);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; req = '0; op = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (grant != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(output logic [NREQ-1:0] d, output bit ok);
    ok = 1'b0; d = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done != '0) begin ok = 1'b1; d = done; break; end
    end
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] op;
    int              win;
    logic            qexp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] d;
    logic [NREQ-1:0] rq, o;
    bit              ok, bad, expq;
    int              mp, ew, n;

    // Round-robin pointer chains through the table starting from 0.
    tbl[0] = '{4'b0001, 4'b0001, 0, 1'b1};
    tbl[1] = '{4'b0001, 4'b0000, 0, 1'b0};
    tbl[2] = '{4'b1100, 4'b0100, 2, 1'b1};
    tbl[3] = '{4'b0110, 4'b0000, 1, 1'b0};
    tbl[4] = '{4'b1011, 4'b1000, 3, 1'b1};
    tbl[5] = '{4'b0100, 4'b0000, 2, 1'b0};
    tbl[6] = '{4'b1000, 4'b1000, 3, 1'b1};

    ack = 1'b0; q = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done",  32'(done),  0);
    chk("rst_q_out", 32'(q_out), 0);
    chk("rst_err",   32'(err),   0);
    chk("rst_s",     32'(s),     0);
    chk("rst_r",     32'(r),     0);

    // Table-driven single transactions; req dropped once granted.
    foreach (tbl[i]) begin
      saw_s = 1'b0; saw_r = 1'b0;
      req = tbl[i].req; op = tbl[i].op;
      wait_grant(ok);
      chk("tbl_grant_seen", 32'(ok), 1);
      chk("tbl_grant", 32'(grant), 32'(4'b0001 << tbl[i].win));
      req = '0;
      wait_done(d, ok);
      chk("tbl_done_seen", 32'(ok), 1);
      chk("tbl_done", 32'(d), 32'(4'b0001 << tbl[i].win));
      chk("tbl_q_out", 32'(q_out), 32'(tbl[i].qexp));
      chk("tbl_saw_s", 32'(saw_s), 32'(tbl[i].op[tbl[i].win]));
      chk("tbl_saw_r", 32'(saw_r), 32'(!tbl[i].op[tbl[i].win]));
      repeat (3) @(negedge clk);
    end

    // Latency: req seen at edge N, grant after N+1, s after N+2.
    req = 4'b0001; op = 4'b0001;
    @(posedge clk); #1;
    chk("lat_grant_n", 32'(grant), 0);
    @(posedge clk); #1;
    chk("lat_grant_n1", 32'(grant), 32'(4'b0001));
    chk("lat_s_n1", 32'(s), 0);
    @(posedge clk); #1;
    chk("lat_s_n2", 32'(s), 1);
    req = '0;
    wait_done(d, ok);
    chk("lat_done", 32'(d), 32'(4'b0001));
    repeat (3) @(negedge clk);

    // Randomized traffic; first iterations are full contention.
    mp = 1;
    for (int it = 0; it < 16; it++) begin
      rq = (it < 5) ? 4'hF : 4'($urandom_range(1, 15));
      o  = 4'($urandom);
      ack_dly = $urandom_range(1, 4);
      req = rq; op = o;
      ew = -1;
      for (int k = 0; k < NREQ; k++)
        if (ew < 0 && rq[(mp + k) % NREQ]) ew = (mp + k) % NREQ;
      wait_done(d, ok);
      chk("rnd_done_seen", 32'(ok), 1);
      chk("rnd_done", 32'(d), 32'(4'b0001 << ew));
      chk("rnd_q_out", 32'(q_out), 32'(o[ew]));
      mp = (ew + 1) % NREQ;
      @(negedge clk);
    end
    req = '0;
    ack_dly = 3;
    repeat (3) @(negedge clk);

    // Requester 1 drops req during the lowering phase.
    expq = ~q;
    req = 4'b0010; op = {2'b00, expq, 1'b0};
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s || r) begin ok = 1'b1; break; end
    end
    chk("drop_raise_seen", 32'(ok), 1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!(s || r)) begin ok = 1'b1; break; end
    end
    chk("drop_lower_seen", 32'(ok), 1);
    req = '0;
    wait_done(d, ok);
    chk("drop_done", 32'(d), 32'(4'b0010));
    chk("drop_q_out", 32'(q_out), 32'(expq));
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (grant != '0) bad = 1'b1;
    end
    chk("drop_no_regrant", 32'(bad), 0);

    // Reset while the latch is acknowledging; no grant until ack clears.
    ack_dly = 2; rel_dly = 12;
    req = 4'b0001; op = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack) begin ok = 1'b1; break; end
    end
    chk("rmo_ack_seen", 32'(ok), 1);
    rst = 1'b1; req = '0;
    @(posedge clk); #1;
    chk("rmo_s", 32'(s), 0);
    chk("rmo_r", 32'(r), 0);
    chk("rmo_grant", 32'(grant), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    req = 4'b0001;
    bad = 1'b0; n = 0;
    while (ack && n < 40) begin
      @(negedge clk);
      n++;
      if (grant != '0 && ack) bad = 1'b1;
    end
    chk("rmo_no_grant_while_ack", 32'(bad), 0);
    rel_dly = 2;
    wait_grant(ok);
    chk("rmo_grant_after_ack", 32'(ok), 1);
    req = '0;
    wait_done(d, ok);
    chk("rmo_done", 32'(d), 32'(4'b0001));
    repeat (3) @(negedge clk);

    // Dead latch: handshake timeout locks the block into error.
    ack_never = 1'b1;
    req = 4'b0001; op = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s) begin ok = 1'b1; break; end
    end
    chk("to_s_seen", 32'(ok), 1);
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("to_err", 32'(err), 1);
    chk("to_cycles", 32'(n >= 253 && n <= 256), 1);
    chk("to_s", 32'(s), 0);
    chk("to_r", 32'(r), 0);
    chk("to_grant", 32'(grant), 0);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (grant != '0 || !err) bad = 1'b1;
    end
    chk("to_locked", 32'(bad), 0);
    ack_never = 1'b0;
    do_reset();
    @(negedge clk);
    chk("to_err_cleared", 32'(err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/srlatch_handshake_arbiter.md
Name: srlatch_handshake_arbiter

Overview:
- Clocked controller that shares one asynchronous SR latch (srlatch_imp: inputs s, r; outputs q, ack) among NREQ synchronous requesters.
- Each requester asks for a set or a reset operation. The block round-robin arbitrates between them and drives a four-phase bundled-data handshake on s/r/ack.
- It returns the settled latch value and a one-cycle done pulse to the winner, and flags a sticky error if ack never responds.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 255, maximum cycles waited in either ack phase before error; counter width is clog2(TIMEOUT+1).
- SYNC_STAGES, 2, flip-flop depth of the ack and q synchronizers (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- op  input  NREQ  per-requester operation: 1 = set (drive s), 0 = reset (drive r); sampled at grant.
- grant  output  NREQ  one-hot; high for the whole transaction of the current winner.
- done  output  NREQ  one-hot, one-cycle pulse at transaction completion.
- q_out  output  1  synchronized latch value captured at completion.
- err  output  1  sticky handshake-timeout flag.
- s  output  1  latch set request.
- r  output  1  latch reset request.
- ack  input  1  latch acknowledge (asynchronous; synchronized internally).
- q  input  1  latch state (asynchronous; synchronized internally).

Behaviour:
- Reset values: grant=0, done=0, q_out=0, err=0, s=0, r=0, state=IDLE, rr pointer=0, timeout counter=0, synchronizer flops=0.
- Reset mid-transaction forces s=r=0 at the reset edge.
- ack_s and q_s are outputs of SYNC_STAGES-deep synchronizers. Only the synchronized values are used.
- States: IDLE, GRANT, RAISE, LOWER, DONE, ERR.
- IDLE:
  - Arbitrates only when some req bit=1 and ack_s=0. This guards the case where the latch is still acknowledging after a reset.
  - Winner = first set req bit searching from index ptr upward, wrapping modulo NREQ.
  - Registers winner index and op[winner], then goes to GRANT.
- GRANT: grant[winner]=1, then goes to RAISE. Latency: req sampled at edge N gives grant visible after edge N+1 and s/r visible after edge N+2.
- RAISE:
  - Drives s=op_reg and r=~op_reg; the two are never both 1.
  - When ack_s=1, goes to LOWER and clears the counter.
- LOWER:
  - Drives s=r=0.
  - When ack_s=0, goes to DONE.
- DONE:
  - done[winner]=1 for exactly one cycle and q_out<=q_s.
  - grant drops at the exit edge and ptr<=(winner+1) mod NREQ.
  - Next state is IDLE.
- Requester rules:
  - Requester must hold req and op stable while grant is high.
  - req still high after done counts as a new request and is arbitrated normally. Others therefore win first if pending.
  - Dropping req while granted is ignored; the transaction completes.
- Timeout:
  - Counter increments each cycle in RAISE or LOWER and clears on each state change.
  - Reaching TIMEOUT goes to ERR.
- ERR:
  - s=r=0, grant=0, done=0, err=1.
  - No further arbitration; the block stays in ERR until rst.
- Simultaneous requests: at most one grant at a time. A requester that loses stays pending and is served in round-robin order.
- Arithmetic: ptr and winner are clog2(NREQ) bits; wrap from NREQ-1 to 0.

Test Plan:
- Single set: rst 2 cycles, then req=4'b0001, op=4'b0001. Latch model acks after 3 cycles. Expected: grant=0001, s=1 until ack_s, s falls, done[0] pulses once, q_out=1, r never 1.
- Contention/fairness: req=4'b1111 held high, ops alternate. Expected grant order 0,1,2,3,0. done pulses carry matching indices and never overlap. No back-to-back grant to the same index while others are pending.
- Reset op: winner requester 2, op[2]=0. Expected: r=1 and s=0 during RAISE, q_out=0 at done[2], ptr moves to 3, next grant to index 3 if pending.
- Timeout: latch model never raises ack, TIMEOUT=255. Expected: err=1 after 255 RAISE cycles, s/r=0, grant=0; later req gets no grant until rst clears err.
- Reset mid-op: assert rst while in RAISE with ack high. Expected: s=r=0 after that edge. Then with req pending, no grant while ack_s=1; grant appears only after ack_s returns to 0.
- Dropped req: requester 1 deasserts req during LOWER. Expected: transaction still completes with done[1] pulse and q_out updated; no re-grant to 1.
